// File: rtl/timer_unit.sv
// Memory-mapped down-counting timer with one-shot (sticky IRQ) and auto-reload (pulsed IRQ) modes.
// Optional clock prescaler for the count phase is compiled in with `define TIMER_PRESCALE_EN.
module timer_unit #(
  parameter int PRESCALE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic [31:0] w_count_next;
  logic        r_irq_flag;
  logic        w_flag_set;
  logic        w_fsm_clr_en;
  logic        w_step;
  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic        w_enable;
  logic        w_auto;
  logic        w_im;

  assign w_enable    = r_ctrl[0];
  assign w_auto      = (r_ctrl[2:1] == 2'b01);
  assign w_im        = r_ctrl[3];
  assign w_wr_ctrl   = WE && (Addr == 2'd0);
  assign w_wr_preset = WE && (Addr == 2'd1);
  assign o_dbg_state = r_state;

`ifdef TIMER_PRESCALE_EN
  localparam logic [7:0] PSC_LAST = 8'(PRESCALE - 1);
  logic [7:0] r_psc;

  // Prescaler only runs in CNT, so every entry into CNT starts from 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_psc <= 8'd0;
    end else if (r_state != S_CNT) begin
      r_psc <= 8'd0;
    end else if (r_psc == PSC_LAST) begin
      r_psc <= 8'd0;
    end else begin
      r_psc <= r_psc + 8'd1;
    end
  end

  assign w_step = (r_psc == PSC_LAST);
`else
  logic [31:0] w_unused_prescale;
  assign w_unused_prescale = 32'(PRESCALE);
  assign w_step = 1'b1;
`endif

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_flag_set   = 1'b0;
    w_fsm_clr_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_enable) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        w_count_next = r_preset;
        w_state_next = S_CNT;
      end
      S_CNT: begin
        if (!w_enable) begin
          w_state_next = S_IDLE;
        end else if (w_step) begin
          if (r_count > 32'd1) begin
            w_count_next = r_count - 32'd1;
          end else begin
            w_count_next = 32'd0;
            w_state_next = S_INT;
            w_flag_set   = !w_auto;
          end
        end
      end
      S_INT: begin
        if (w_auto) begin
          w_state_next = S_LOAD;
        end else begin
          w_fsm_clr_en = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    // Bus writes override the FSM: disabling or reprogramming freezes COUNT and parks in IDLE.
    if (w_wr_ctrl && !Din[0]) begin
      w_state_next = S_IDLE;
      w_count_next = r_count;
    end
    if (w_wr_preset) begin
      w_state_next = S_IDLE;
      w_count_next = r_count;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ctrl     <= 4'd0;
      r_preset   <= 32'd0;
      r_count    <= 32'd0;
      r_irq_flag <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      if (w_wr_ctrl) begin
        r_ctrl <= Din[3:0];
      end else if (w_fsm_clr_en) begin
        r_ctrl[0] <= 1'b0;
      end
      if (w_wr_preset) r_preset <= Din;
      if (w_wr_ctrl) begin
        r_irq_flag <= 1'b0;
      end else if (w_flag_set) begin
        r_irq_flag <= 1'b1;
      end
    end
  end

  always_comb begin
    case (Addr)
      2'd0:    Dout = {28'd0, r_ctrl};
      2'd1:    Dout = r_preset;
      2'd2:    Dout = r_count;
      default: Dout = 32'd0;
    endcase
  end

  assign IRQ = w_im & (r_irq_flag | ((r_state == S_INT) & w_auto));

endmodule

// File: doc/timer_unit.md
Name: timer_unit

Overview:
- Memory-mapped down-counting timer on the P7 system bridge.
- Its IRQ output drives one bit of the CPU's HWInt[5:0] bus into the coprocessor-0 interrupt logic, conventionally HWInt[0].
- Software programs it with sw and inspects it with lw through three word registers.
- Supports a one-shot mode with a sticky interrupt and an auto-reload mode with a periodic single-cycle interrupt.

Parameters:
- PRESCALE, 4: decrement period in clk cycles. Used only when TIMER_PRESCALE_EN is defined; legal range 1..256.

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high reset
- Addr  input  2  word select, bridge address bits [3:2]: 0=CTRL, 1=PRESET, 2=COUNT, 3=unused
- WE  input  1  write strobe for the register selected by Addr
- Din  input  32  write data
- Dout  output  32  read data for the register selected by Addr (combinational)
- IRQ  output  1  interrupt request to HWInt

Behaviour:
- Registers:
  - CTRL[3:0]: bit0 Enable, bits[2:1] Mode, bit3 IM (interrupt mask). CTRL[31:4] always read as 0.
  - Mode 00 = one-shot; 01 = auto-reload; 1x is reserved and treated as 00.
  - PRESET[31:0] is read/write. COUNT[31:0] is read-only; writes to Addr 2 or 3 are ignored.
  - Addr 3 reads as 0.
- Reset: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, FSM=IDLE. Consequently Dout=0 for every Addr and IRQ=0.
- FSM states and transitions:
  - IDLE: if Enable=1, go to LOAD; otherwise stay. COUNT holds.
  - LOAD: COUNT<=PRESET, then go to CNT.
  - CNT, Enable=0: go to IDLE; COUNT holds its value.
  - CNT, COUNT>1: COUNT<=COUNT-1, stay in CNT.
  - CNT, COUNT<=1: COUNT<=0, go to INT. In one-shot mode, irq_flag<=1 on this same edge.
  - INT, one-shot: Enable<=0, go to IDLE.
  - INT, auto-reload: go to LOAD.
- IRQ = IM & (irq_flag | (state==INT & Mode==01)).
  - One-shot IRQ is sticky until cleared by software.
  - Auto-reload IRQ is a one-cycle pulse.
- Latency:
  - After the edge that writes Enable=1 (edge 0), the FSM enters INT at edge max(PRESET,1)+2.
  - IRQ is visible in the cycle following that edge.
  - Auto-reload period between pulses is max(PRESET,1)+2 cycles.
- Bus write of CTRL:
  - Din[3:0] is stored and irq_flag is cleared.
  - If the new Enable=0, the FSM goes to IDLE.
  - If the new Enable=1, the FSM keeps its state.
- Bus write of PRESET: PRESET is stored and the FSM goes to IDLE. If Enable=1, the next edge goes to LOAD, so a write during counting restarts the count.
- Simultaneous events: a bus write takes priority over the FSM.
  - A CTRL write in the same cycle the FSM is in INT (one-shot) keeps the written Enable; the FSM's Enable<=0 is discarded.
  - A CTRL write in the same cycle as CNT->INT (one-shot) leaves irq_flag=0; the clear wins.
- Reset asserted mid-count returns everything to reset values on that edge and aborts any pending IRQ.
- COUNT never wraps below 0.
- IM=0 masks IRQ but does not stop counting or clear irq_flag. Setting IM=1 later exposes a pending one-shot flag, unless the write that sets IM also clears the flag, which it does (any CTRL write clears irq_flag).

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- Defined: an 8-bit prescaler counts clk cycles in the CNT state and resets to 0 on entering CNT.
  - The CNT decrement/compare step executes only when prescaler==PRESCALE-1, after which the prescaler wraps to 0.
  - The Enable=0 exit from CNT still takes effect immediately.
  - All CNT-phase latencies scale by PRESCALE.
- Undefined: the CNT step executes every cycle, PRESCALE is ignored, and no prescaler logic exists.

Test Plan:
1. Reset, then read Addr 0/1/2 -> Dout=0 each, IRQ=0. Write Addr 2 with 0xFFFF -> COUNT still reads 0.
2. PRESET=5, then CTRL=0x9 (IM, one-shot, Enable) -> IRQ rises in the cycle after edge 7 and stays high. CTRL reads 0x8 (Enable auto-cleared), COUNT=0. Writing CTRL=0x8 drops IRQ the next cycle.
3. PRESET=3, CTRL=0xB (auto-reload) -> IRQ is a 1-cycle pulse every 5 cycles. COUNT reads cycle 3,2,1,0,0,3... Writing CTRL=0 -> no further pulses, COUNT holds.
4. PRESET=0 and PRESET=1, one-shot, IM=1 -> both raise IRQ after edge 3.
5. PRESET=10 running; at COUNT=4 write PRESET=2 -> COUNT reloads to 2 two edges later, IRQ after a further 2 edges. Asserting reset mid-count -> COUNT=0 and no IRQ thereafter.
6. Build with TIMER_PRESCALE_EN and PRESCALE=4, PRESET=2, one-shot -> COUNT steps once every 4 cycles in CNT, and IRQ arrives 8 cycles after entering CNT.
